// File: rtl/phase_seq_gen.sv
// phase_seq_gen: produces the per-element phase codes for one linear
// beam-steering row, phase[k] = (offset + k*step) mod 2^PH_W, one element per
// clock. A hold input stalls the sequence. A one-cycle done pulse follows the
// last element.
//
// Output handshake: phase_valid=1 marks the single cycle in which
// phase_out/elem_idx carry a new element. There is no ready signal. The
// consumer stalls the stream by raising hold. While hold is high, phase_valid
// stays low and nothing advances. The element after the stall is the next one
// in order, so no element is skipped and none is repeated with phase_valid=1.
module phase_seq_gen #(
  parameter int PH_W   = 5,
  parameter int N_ELEM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PH_W-1:0]  phase_step,
  input  logic [PH_W-1:0]  phase_offset,
  input  logic             hold,
  output logic [PH_W-1:0]  phase_out,
  output logic             phase_valid,
  output logic [IDX_W-1:0] elem_idx,
  output logic             busy,
  output logic             done,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  state_t          state;
  logic [PH_W-1:0] step_q;

  // Debug view of the FSM: 1 while a sequence is running.
  assign state_dbg = (state == RUN);

  // Sequencer FSM with registered outputs. The phase accumulates the latched
  // step. The PH_W-bit add drops the carry, which gives the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step_q      <= '0;
      phase_out   <= '0;
      phase_valid <= 1'b0;
      elem_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done        <= 1'b0;
          phase_valid <= 1'b0;
          if (start) begin
            step_q      <= phase_step;
            phase_out   <= phase_offset;
            elem_idx    <= '0;
            phase_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (hold) begin
            phase_valid <= 1'b0;
          end else if (elem_idx == LAST_IDX) begin
            phase_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            elem_idx    <= '0;
            state       <= IDLE;
          end else begin
            phase_out   <= phase_out + step_q;
            elem_idx    <= elem_idx + IDX_W'(1);
            phase_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_seq_gen.sv
// Testbench for phase_seq_gen. A behavioural model predicts every output on
// every cycle. A scoreboard queue holds the element stream implied by
// offset + k*step. Directed scenarios pin the model with hand-computed
// literal values.
module tb_phase_seq_gen;

  localparam int PH_W   = 5;
  localparam int N_ELEM = 16;
  localparam int IDX_W  = 4;
  localparam int MODV   = 1 << PH_W;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PH_W-1:0]  phase_step;
  logic [PH_W-1:0]  phase_offset;
  logic             hold;
  logic [PH_W-1:0]  phase_out;
  logic             phase_valid;
  logic [IDX_W-1:0] elem_idx;
  logic             busy;
  logic             done;
  logic             state_dbg;

  always #5 clk = ~clk;

  phase_seq_gen #(.PH_W(PH_W), .N_ELEM(N_ELEM), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .phase_step   (phase_step),
    .phase_offset (phase_offset),
    .hold         (hold),
    .phase_out    (phase_out),
    .phase_valid  (phase_valid),
    .elem_idx     (elem_idx),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [IDX_W+PH_W-1:0] exp_q[$];   // {idx, phase} of elements still owed
  logic [PH_W-1:0]       got_q[$];   // phases seen with phase_valid=1

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // The model describes a sequence as "element k of (off, step)". Its
  // outputs follow from k, from whether a stall happened this cycle, and
  // from whether the row is complete.
  int m_active, m_k, m_step, m_off;
  int m_phase, m_valid, m_idx, m_busy, m_done;

  initial begin
    m_active = 0; m_k = 0; m_step = 0; m_off = 0;
    m_phase = 0; m_valid = 0; m_idx = 0; m_busy = 0; m_done = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_k = 0; m_step = 0;
      m_phase = 0; m_valid = 0; m_idx = 0; m_busy = 0; m_done = 0;
      exp_q.delete();
    end else if (m_active == 0) begin
      m_done  = 0;
      m_valid = 0;
      if (start) begin
        m_active = 1;
        m_step   = int'(phase_step);
        m_off    = int'(phase_offset);
        m_k      = 0;
        m_phase  = m_off;
        m_idx    = 0;
        m_valid  = 1;
        m_busy   = 1;
        for (int k = 0; k < N_ELEM; k++)
          exp_q.push_back({IDX_W'(k), PH_W'((m_off + k * m_step) % MODV)});
      end
    end else if (hold) begin
      m_valid = 0;
    end else if (m_k == N_ELEM - 1) begin
      m_active = 0;
      m_valid  = 0;
      m_busy   = 0;
      m_done   = 1;
      m_idx    = 0;
    end else begin
      m_k     = m_k + 1;
      m_phase = (m_off + m_k * m_step) % MODV;
      m_idx   = m_k;
      m_valid = 1;
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  logic [IDX_W+PH_W-1:0] sb_e;

  always @(negedge clk) begin
    check("phase_out",   32'(phase_out),   32'(m_phase));
    check("phase_valid", 32'(phase_valid), 32'(m_valid));
    check("elem_idx",    32'(elem_idx),    32'(m_idx));
    check("busy",        32'(busy),        32'(m_busy));
    check("done",        32'(done),        32'(m_done));
    check("state_dbg",   32'(state_dbg),   32'(m_active));
    if (phase_valid === 1'b1) begin
      got_q.push_back(phase_out);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_elem", 32'(phase_out), 32'hFFFF_FFFF);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_elem", 32'({elem_idx, phase_out}), 32'(sb_e));
      end
    end
  end

  // ---------------- driver ----------------
  // Starts a sequence and runs it until done. cycles is the count of clocks
  // from the start edge until the clock where done is seen. Optional
  // disturbances, keyed on that count:
  //   hold_at : hold high for 3 clocks from this count
  //   inj_at  : a stray start with step=7 offset=9
  //   rst_at  : reset pulse; the task returns one clock later
  task automatic run_seq(input logic [PH_W-1:0] s, input logic [PH_W-1:0] o,
                         input bit immediate, input int hold_at,
                         input int inj_at, input int rst_at,
                         output int cycles);
    bit fin;
    cycles = -1;
    fin    = 1'b0;
    if (!immediate) @(negedge clk);
    got_q.delete();
    start        = 1'b1;
    phase_step   = s;
    phase_offset = o;
    for (int cnt = 1; cnt <= 100 && !fin; cnt++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = cnt;
        fin    = 1'b1;
      end else begin
        if (cnt == 1) begin
          // Changing the inputs after the start edge exercises the latched copies.
          start        = 1'b0;
          phase_step   = ~s;
          phase_offset = ~o;
        end
        if (hold_at > 0) hold = (cnt >= hold_at) && (cnt < hold_at + 3);
        if (inj_at > 0 && cnt == inj_at) begin
          start = 1'b1; phase_step = 5'd7; phase_offset = 5'd9;
        end else if (inj_at > 0 && cnt == inj_at + 1) begin
          start = 1'b0;
        end
        if (rst_at > 0 && cnt == rst_at) rst = 1'b1;
        if (rst_at > 0 && cnt == rst_at + 1) begin
          rst    = 1'b0;
          cycles = cnt;
          fin    = 1'b1;
        end
      end
    end
    if (!fin) check("timeout_waiting_done", 32'(cycles), 32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  int s1_exp[16] = '{0, 3, 6, 9, 12, 15, 18, 21, 24, 27, 30, 1, 4, 7, 10, 13};
  int cyc;

  task automatic check_s1_list(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check({tag, "_elem"}, 32'(got_q[i]), 32'(s1_exp[i]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    phase_step = '0; phase_offset = '0;
    repeat (3) @(negedge clk);
    check("reset_phase_out", 32'(phase_out),   32'd0);
    check("reset_valid",     32'(phase_valid), 32'd0);
    check("reset_idx",       32'(elem_idx),    32'd0);
    check("reset_busy",      32'(busy),        32'd0);
    check("reset_done",      32'(done),        32'd0);
    rst = 1'b0;

    // 1: step 3 from offset 0, done on the 17th clock
    run_seq(5'd3, 5'd0, 1'b0, 0, 0, 0, cyc);
    check("s1_cycles_to_done", 32'(cyc), 32'd17);
    check_s1_list("s1");

    // 2: step 1 from offset 31 wraps to 0
    run_seq(5'd1, 5'd31, 1'b0, 0, 0, 0, cyc);
    check("s2_cycles_to_done", 32'(cyc), 32'd17);
    check("s2_count", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) begin
      check("s2_elem0",  32'(got_q[0]),  32'd31);
      check("s2_elem1",  32'(got_q[1]),  32'd0);
      check("s2_elem15", 32'(got_q[15]), 32'd14);
    end

    // 3: 3-clock stall while idx 5 (phase 15) is showing
    run_seq(5'd3, 5'd0, 1'b0, 6, 0, 0, cyc);
    check("s3_cycles_to_done", 32'(cyc), 32'd20);
    check_s1_list("s3");

    // 4: start during RUN with other step/offset is ignored
    run_seq(5'd3, 5'd0, 1'b0, 0, 4, 0, cyc);
    check("s4_cycles_to_done", 32'(cyc), 32'd17);
    check_s1_list("s4");

    // 5: reset while idx 8 is showing, then a fresh step 2 / offset 4 row
    run_seq(5'd3, 5'd0, 1'b0, 0, 0, 9, cyc);
    check("s5_rst_phase_out", 32'(phase_out),   32'd0);
    check("s5_rst_valid",     32'(phase_valid), 32'd0);
    check("s5_rst_idx",       32'(elem_idx),    32'd0);
    check("s5_rst_busy",      32'(busy),        32'd0);
    check("s5_rst_done",      32'(done),        32'd0);
    run_seq(5'd2, 5'd4, 1'b0, 0, 0, 0, cyc);
    check("s5_cycles_to_done", 32'(cyc), 32'd17);
    check("s5_count", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) begin
      check("s5_elem0",  32'(got_q[0]),  32'd4);
      check("s5_elem1",  32'(got_q[1]),  32'd6);
      check("s5_elem2",  32'(got_q[2]),  32'd8);
      check("s5_elem15", 32'(got_q[15]), 32'd2);
    end

    // 6: step 0 gives a constant phase, then a start on the done cycle
    run_seq(5'd0, 5'd17, 1'b0, 0, 0, 0, cyc);
    check("s6_cycles_to_done", 32'(cyc), 32'd17);
    check("s6_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < got_q.size(); i++)
      check("s6_const_elem", 32'(got_q[i]), 32'd17);
    run_seq(5'd5, 5'd2, 1'b1, 0, 0, 0, cyc);
    check("s6_chain_cycles", 32'(cyc), 32'd17);
    check("s6_chain_count", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) begin
      check("s6_chain_elem0",  32'(got_q[0]),  32'd2);
      check("s6_chain_elem15", 32'(got_q[15]), 32'd13);
    end

    repeat (3) @(negedge clk);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
